// File: rtl/hazard_pkg.sv
// Shared constants and the latency-class helper for the decode interlock.
// No logic of its own; lat() is pure combinational.
// No flow control.
package hazard_pkg;

  // Latency classes presented on ID_CLASS; 3 is decoded as ALU.
  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_LOAD = 2'd1;
  localparam logic [1:0] CLS_MUL  = 2'd2;

  // Stall cause codes reported on STALL_CAUSE.
  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_RAW    = 2'd1;
  localparam logic [1:0] CAUSE_STRUCT = 2'd2;
  localparam logic [1:0] CAUSE_WAW    = 2'd3;

  // Cycles after issue until the result of a class becomes forwardable.
  function automatic int unsigned lat(input logic [1:0] cls, input int unsigned mul_lat);
    case (cls)
      CLS_LOAD: lat = 1;
      CLS_MUL:  lat = mul_lat;
      default:  lat = 0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown of cycles until each in-flight result is forwardable.
// Loads land on the next edge; reads are combinational from registered state.
// No flow control: a load is accepted every cycle ld_en_i is high.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W    = 4,
  parameter int CNT_W    = 3,
  parameter int ZERO_REG = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_en_i,
  input  logic [REG_W-1:0] ld_reg_i,
  input  logic [CNT_W-1:0] ld_val_i,
  input  logic [REG_W-1:0] rd1_reg_i,
  input  logic [REG_W-1:0] rd2_reg_i,
  input  logic [REG_W-1:0] rdd_reg_i,
  output logic [CNT_W-1:0] rd1_cnt_o,
  output logic [CNT_W-1:0] rd2_cnt_o,
  output logic [CNT_W-1:0] rdd_cnt_o
);

  localparam int NREG = 1 << REG_W;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             ld_ok;

  // A write to the hardwired zero register never makes it pending.
  always_comb begin
    ld_ok = ld_en_i;
    if ((ZERO_REG != 0) && (ld_reg_i == '0)) ld_ok = 1'b0;
  end

  // Issue load wins over the free-running decrement of the same entry.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (ld_ok && (ld_reg_i == REG_W'(r))) begin
        cnt_d[r] = ld_val_i;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  // Counter array with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Three read ports; register 0 reads as idle when hardwired.
  always_comb begin
    rd1_cnt_o = cnt_q[rd1_reg_i];
    rd2_cnt_o = cnt_q[rd2_reg_i];
    rdd_cnt_o = cnt_q[rdd_reg_i];
    if ((ZERO_REG != 0) && (rd1_reg_i == '0)) rd1_cnt_o = '0;
    if ((ZERO_REG != 0) && (rd2_reg_i == '0)) rd2_cnt_o = '0;
    if ((ZERO_REG != 0) && (rdd_reg_i == '0)) rdd_cnt_o = '0;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode interlock: load-use, multiplier latency/occupancy and WAW stalls.
// Zero-cycle decision: ISSUE/STALL/STALL_CAUSE are combinational.
// Stalls hold PC and IF/ID and bubble ID/EXE; FLUSH kills the decode slot.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_W    = 4,
  parameter int CNT_W    = 3,
  parameter int MUL_LAT  = 3,   // must lie in 2 .. 2**CNT_W-1
  parameter int ZERO_REG = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ID_VALID,
  input  logic [REG_W-1:0] ID_OP1,
  input  logic [REG_W-1:0] ID_OP2,
  input  logic             ID_USE1,
  input  logic             ID_USE2,
  input  logic [REG_W-1:0] ID_DEST,
  input  logic             ID_WB,
  input  logic [1:0]       ID_CLASS,
  input  logic             FLUSH,
  output logic             ISSUE,
  output logic             STALL,
  output logic [1:0]       STALL_CAUSE,
  output logic [15:0]      STALL_CNT
);

  logic [CNT_W-1:0] op1_cnt, op2_cnt, dest_cnt;
  logic [CNT_W-1:0] lat_cur;
  logic [CNT_W-1:0] mul_busy_q, mul_busy_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             raw_haz, struct_haz, waw_haz, any_haz;
  logic             decode_live, sb_ld_en;

  hazard_scoreboard #(
    .REG_W    (REG_W),
    .CNT_W    (CNT_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i     (CLK),
    .rst_i     (RST),
    .ld_en_i   (sb_ld_en),
    .ld_reg_i  (ID_DEST),
    .ld_val_i  (lat_cur),
    .rd1_reg_i (ID_OP1),
    .rd2_reg_i (ID_OP2),
    .rdd_reg_i (ID_DEST),
    .rd1_cnt_o (op1_cnt),
    .rd2_cnt_o (op2_cnt),
    .rdd_cnt_o (dest_cnt)
  );

  // Hazard detection against current scoreboard and multiplier occupancy.
  always_comb begin
    lat_cur     = CNT_W'(lat(ID_CLASS, MUL_LAT));
    raw_haz     = (ID_USE1 && (op1_cnt != '0)) || (ID_USE2 && (op2_cnt != '0));
    struct_haz  = (ID_CLASS == CLS_MUL) && (mul_busy_q != '0);
    // A younger result must not land before an older one to the same register.
    waw_haz     = ID_WB && (dest_cnt > lat_cur);
    any_haz     = raw_haz || struct_haz || waw_haz;
    decode_live = ID_VALID && !FLUSH && !RST;
    STALL       = decode_live && any_haz;
    ISSUE       = decode_live && !any_haz;
    sb_ld_en    = ISSUE && ID_WB;
  end

  // Cause priority RAW > structural > WAW; reported only while stalling.
  always_comb begin
    STALL_CAUSE = CAUSE_NONE;
    if (STALL) begin
      if (raw_haz)         STALL_CAUSE = CAUSE_RAW;
      else if (struct_haz) STALL_CAUSE = CAUSE_STRUCT;
      else                 STALL_CAUSE = CAUSE_WAW;
    end
  end

  // Multiplier occupancy and saturating stall counter next state.
  always_comb begin
    mul_busy_d = mul_busy_q;
    if (ISSUE && (ID_CLASS == CLS_MUL)) begin
      mul_busy_d = CNT_W'(MUL_LAT - 1);
    end else if (mul_busy_q != '0) begin
      mul_busy_d = mul_busy_q - 1'b1;
    end
    stall_cnt_d = stall_cnt_q;
    if (STALL && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mul_busy_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      mul_busy_q  <= mul_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-stage interlock; the stall-side counterpart of the forwarding unit. The forwarding unit resolves hazards whose producer value already sits in EXE/MEM or MEM/WB. This block detects hazards forwarding cannot cover: load-use, multi-cycle multiply, write-after-write ordering, and multiplier busy. On a hazard it holds PC and IF/ID and inserts a bubble into ID/EXE. It keeps a per-register scoreboard of cycles remaining until each in-flight result becomes forwardable.

## Interface
Parameters:
- REG_W, 4: register-ID width; 2^REG_W scoreboard entries.
- CNT_W, 3: countdown width.
- MUL_LAT, 3: multiplier occupancy/result latency in cycles; legal range 2..(2^CNT_W - 1).
- ZERO_REG, 1: when 1, register 0 is hardwired zero and is never pending.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- ID_VALID  in  1  decode holds a real instruction.
- ID_OP1, ID_OP2  in  REG_W  source register IDs.
- ID_USE1, ID_USE2  in  1  the corresponding source is actually read.
- ID_DEST  in  REG_W  destination register ID.
- ID_WB  in  1  instruction writes ID_DEST.
- ID_CLASS  in  2  latency class: 0 ALU, 1 LOAD, 2 MUL; 3 is treated as ALU.
- FLUSH  in  1  kill the decode-stage instruction (branch redirect).
- ISSUE  out  1  decode instruction advances into EXE this cycle.
- STALL  out  1  hold PC and IF/ID, insert NOP into ID/EXE.
- STALL_CAUSE  out  2  0 none, 1 RAW, 2 structural (MUL busy), 3 WAW.
- STALL_CNT  out  16  saturating count of stalled cycles.

## Operation
- Scoreboard: cnt[r], CNT_W bits per register, giving cycles until r is forwardable.
- Every cycle, each nonzero cnt decrements by 1.
- On ISSUE with ID_WB=1, cnt[ID_DEST] is loaded with lat(class): ALU 0, LOAD 1, MUL MUL_LAT. The load overrides that register's decrement.
- No load occurs when ZERO_REG=1 and ID_DEST=0.
- mul_busy: CNT_W-bit counter, loaded with MUL_LAT-1 on MUL issue and decremented while nonzero. A MUL may issue only when mul_busy=0.
- RAW hazard: (ID_USE1 and cnt[ID_OP1]≠0) or (ID_USE2 and cnt[ID_OP2]≠0).
- Structural hazard: ID_CLASS=MUL and mul_busy≠0.
- WAW hazard: ID_WB and cnt[ID_DEST] > lat(ID_CLASS). This preserves writeback order.
- Cause priority: RAW > structural > WAW.
- STALL = ID_VALID & !FLUSH & any hazard.
- ISSUE = ID_VALID & !FLUSH & !STALL.
- FLUSH: ISSUE=0, STALL=0, STALL_CAUSE=0, no scoreboard load. Existing counters keep decrementing, because older issued instructions still complete.
- STALL_CNT increments on each STALL cycle and saturates at 16'hFFFF.

## Timing
- ISSUE, STALL and STALL_CAUSE are combinational from the current inputs and registered state. There is zero-cycle decision latency.
- A scoreboard load is visible to the next cycle's decode.
- A load followed immediately by a consumer gives exactly 1 stall cycle. The consumer then forwards from MEM/WB.
- A MUL followed immediately by a consumer gives exactly MUL_LAT stall cycles.
- Back-to-back MULs: the second stalls MUL_LAT-1 cycles.
- Reset values: cnt[*]=0, mul_busy=0, STALL_CNT=0.
- While RST=1, ISSUE=0, STALL=0 and STALL_CAUSE=0.
- RST asserted mid-operation clears all pending state in the same edge. No stall persists after reset.
- When STALL holds for several cycles, the decode inputs stay stable. The hazard is re-evaluated every cycle against the decremented counters.

## Structure
- Package hazard_pkg holds:
  - latency-class constants CLS_ALU=0, CLS_LOAD=1, CLS_MUL=2;
  - cause constants CAUSE_NONE/RAW/STRUCT/WAW;
  - function lat(class, MUL_LAT).
- Sub-module hazard_scoreboard owns the counter array, the decrement, the issue load and the ZERO_REG masking. It exposes three read ports (op1, op2, dest).
- The top level holds mul_busy, the hazard and priority logic, and STALL_CNT.

## Test plan
- Load-use: issue LOAD R3, then ADD R5,R3,R1 → 1 cycle with STALL=1, CAUSE=1; ADD issues on the 2nd cycle; STALL_CNT=1.
- MUL chain, MUL_LAT=3: MUL R2 then SUB reading R2 → 3 stall cycles, CAUSE=1. A second MUL right after the first → 2 stall cycles, CAUSE=2.
- WAW: LOAD R4 then ADD writing R4 with no R4 read → 1 stall cycle, CAUSE=3. An ALU producer followed by an ALU writer of the same register → no stall.
- Zero register: LOAD R0 then a reader of R0 → no stall with ZERO_REG=1; 1 stall with ZERO_REG=0.
- Flush: assert FLUSH during a load-use stall → STALL=0, ISSUE=0, no scoreboard load. The next instruction reading R3 one cycle later issues without stall.
- Reset mid-operation: MUL R6 issued, RST on the next cycle, then a reader of R6 → no stall; STALL_CNT=0.
